// File: rtl/multi_phase_signal_controller_pkg.sv
// Shared types and helpers for the multi-phase signal controller.
package multi_phase_signal_controller_pkg;

    // Controller states. The numeric values are visible on the state output.
    typedef enum logic [2:0] {
        GREEN_BASE = 3'd0,
        GREEN_EXT  = 3'd1,
        YELLOW     = 3'd2,
        ALL_RED    = 3'd3,
        WALK       = 3'd4
    } state_t;

    // Lamp column indices, used when a lamp set is handled as a group.
    localparam int unsigned LAMP_GREEN  = 0;
    localparam int unsigned LAMP_YELLOW = 1;
    localparam int unsigned LAMP_RED    = 2;
    localparam int unsigned LAMP_WALK   = 3;

    // Width of the phase index. A 1-phase build would give $clog2 = 0,
    // so the result is clamped to at least one bit.
    function automatic int unsigned phaseWidth(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/multi_phase_signal_controller_countdown.sv
// Tick-driven interval countdown. A load sets the interval length.
// Expiry is signalled on the tick that consumes the last remaining count.
module tick_countdown #(
    parameter int unsigned          CNT_W       = 8,
    parameter logic [CNT_W-1:0]     RESET_VALUE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    input  logic             tick,
    output logic [CNT_W-1:0] remaining,
    output logic             expire
);

    // A load takes priority over a tick. On expiry the owner always reloads,
    // so the counter never steps below 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            remaining <= RESET_VALUE;
        end else if (load) begin
            remaining <= value;
        end else if (tick && (remaining > CNT_W'(1))) begin
            remaining <= remaining - 1'b1;
        end
    end

    // Expiry: a tick arriving while the last count remains.
    always_comb begin
        expire = tick && (remaining == CNT_W'(1));
    end

endmodule

// File: rtl/multi_phase_signal_controller.sv
// N-phase intersection controller: phase sequencing, pedestrian walk,
// demand-based skipping, run-time interval reprogramming and lamp decode.
module multi_phase_signal_controller
    import multi_phase_signal_controller_pkg::*;
#(
    parameter  int unsigned NUM_PHASES   = 4,
    parameter  int unsigned CNT_W        = 8,
    parameter  int unsigned BASE_TICKS   = 10,
    parameter  int unsigned EXT_TICKS    = 5,
    parameter  int unsigned YEL_TICKS    = 3,
    parameter  int unsigned ALLRED_TICKS = 1,
    parameter  int unsigned WALK_TICKS   = 6,
    parameter  int unsigned SKIP_IDLE    = 1,
    localparam int unsigned PH_W         = phaseWidth(NUM_PHASES)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tick,
    input  logic [NUM_PHASES-1:0] traffic_sensor,
    input  logic [NUM_PHASES-1:0] walk_req,
    input  logic                  cfg_load,
    input  logic [CNT_W-1:0]      cfg_base,
    input  logic [CNT_W-1:0]      cfg_ext,
    input  logic [CNT_W-1:0]      cfg_yel,
    input  logic [CNT_W-1:0]      cfg_allred,
    input  logic [CNT_W-1:0]      cfg_walk,
    output logic [NUM_PHASES-1:0] green,
    output logic [NUM_PHASES-1:0] yellow,
    output logic [NUM_PHASES-1:0] red,
    output logic [NUM_PHASES-1:0] walk,
    output logic [PH_W-1:0]       phase,
    output logic [2:0]            state,
    output logic [CNT_W-1:0]      remaining,
    output logic [NUM_PHASES-1:0] walk_pend
);

    // Zero-length intervals are stored as one tick so every state is visited.
    localparam logic [CNT_W-1:0] BASE_INIT   = CNT_W'((BASE_TICKS   == 0) ? 1 : BASE_TICKS);
    localparam logic [CNT_W-1:0] EXT_INIT    = CNT_W'((EXT_TICKS    == 0) ? 1 : EXT_TICKS);
    localparam logic [CNT_W-1:0] YEL_INIT    = CNT_W'((YEL_TICKS    == 0) ? 1 : YEL_TICKS);
    localparam logic [CNT_W-1:0] ALLRED_INIT = CNT_W'((ALLRED_TICKS == 0) ? 1 : ALLRED_TICKS);
    localparam logic [CNT_W-1:0] WALK_INIT   = CNT_W'((WALK_TICKS   == 0) ? 1 : WALK_TICKS);

    function automatic logic [CNT_W-1:0] atLeastOne(input logic [CNT_W-1:0] v);
        return (v == '0) ? CNT_W'(1) : v;
    endfunction

    state_t                stateQ, stateNext;
    logic [PH_W-1:0]       phaseQ, phaseNext, nextPhase, succPhase;
    logic                  restartQ, restartNext;
    logic [NUM_PHASES-1:0] walkPendQ, walkClear, demand;
    logic [CNT_W-1:0]      cfgBase, cfgExt, cfgYel, cfgAllred, cfgWalk;
    logic                  timerLoad, timerExpire;
    logic [CNT_W-1:0]      timerValue;
    logic                  found;

    tick_countdown #(
        .CNT_W       (CNT_W),
        .RESET_VALUE (BASE_INIT)
    ) u_countdown (
        .clk       (clk),
        .reset     (reset),
        .load      (timerLoad),
        .value     (timerValue),
        .tick      (tick && !cfg_load),
        .remaining (remaining),
        .expire    (timerExpire)
    );

    // Next phase: first phase after the current one (wrapping) with demand,
    // the current phase examined last; plain successor when nothing is waiting.
    always_comb begin
        demand    = traffic_sensor | walkPendQ;
        succPhase = (phaseQ == PH_W'(NUM_PHASES - 1)) ? '0 : phaseQ + 1'b1;
        nextPhase = succPhase;
        found     = 1'b0;
        if (SKIP_IDLE != 0) begin
            for (int unsigned k = 1; k <= NUM_PHASES; k++) begin
                int unsigned idx;
                idx = (32'(phaseQ) + k) % NUM_PHASES;
                if (!found && demand[idx[PH_W-1:0]]) begin
                    found     = 1'b1;
                    nextPhase = idx[PH_W-1:0];
                end
            end
        end
    end

    // Next-state logic; cfg_load overrides any same-cycle expiry.
    always_comb begin
        stateNext   = stateQ;
        phaseNext   = phaseQ;
        restartNext = restartQ;
        timerLoad   = 1'b0;
        timerValue  = cfgBase;
        walkClear   = '0;
        if (cfg_load) begin
            stateNext   = ALL_RED;
            restartNext = 1'b1;
            timerLoad   = 1'b1;
            timerValue  = atLeastOne(cfg_allred);
        end else begin
            case (stateQ)
                GREEN_BASE: if (timerExpire) begin
                    timerLoad = 1'b1;
                    if (traffic_sensor[phaseQ]) begin
                        stateNext  = GREEN_EXT;
                        timerValue = cfgExt;
                    end else begin
                        stateNext  = YELLOW;
                        timerValue = cfgYel;
                    end
                end
                GREEN_EXT: if (timerExpire) begin
                    stateNext  = YELLOW;
                    timerLoad  = 1'b1;
                    timerValue = cfgYel;
                end
                YELLOW: if (timerExpire) begin
                    stateNext  = ALL_RED;
                    timerLoad  = 1'b1;
                    timerValue = cfgAllred;
                end
                ALL_RED: if (timerExpire) begin
                    timerLoad = 1'b1;
                    if (restartQ) begin
                        stateNext   = GREEN_BASE;
                        phaseNext   = '0;
                        restartNext = 1'b0;
                        timerValue  = cfgBase;
                    end else if (walkPendQ[phaseQ]) begin
                        stateNext  = WALK;
                        timerValue = cfgWalk;
                    end else begin
                        stateNext  = GREEN_BASE;
                        phaseNext  = nextPhase;
                        timerValue = cfgBase;
                    end
                end
                WALK: if (timerExpire) begin
                    stateNext         = GREEN_BASE;
                    phaseNext         = nextPhase;
                    walkClear[phaseQ] = 1'b1;
                    timerLoad         = 1'b1;
                    timerValue        = cfgBase;
                end
                default: begin
                    stateNext  = ALL_RED;
                    phaseNext  = '0;
                    timerLoad  = 1'b1;
                    timerValue = cfgAllred;
                end
            endcase
        end
    end

    // State, phase, restart flag and pending walks; a new request beats a clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateQ    <= GREEN_BASE;
            phaseQ    <= '0;
            restartQ  <= 1'b0;
            walkPendQ <= '0;
        end else begin
            stateQ    <= stateNext;
            phaseQ    <= phaseNext;
            restartQ  <= restartNext;
            walkPendQ <= (walkPendQ & ~walkClear) | walk_req;
        end
    end

    // Interval configuration registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cfgBase   <= BASE_INIT;
            cfgExt    <= EXT_INIT;
            cfgYel    <= YEL_INIT;
            cfgAllred <= ALLRED_INIT;
            cfgWalk   <= WALK_INIT;
        end else if (cfg_load) begin
            cfgBase   <= atLeastOne(cfg_base);
            cfgExt    <= atLeastOne(cfg_ext);
            cfgYel    <= atLeastOne(cfg_yel);
            cfgAllred <= atLeastOne(cfg_allred);
            cfgWalk   <= atLeastOne(cfg_walk);
        end
    end

    // Lamp decode from registered state and phase; idle phases stay red.
    always_comb begin
        green  = '0;
        yellow = '0;
        red    = '1;
        walk   = '0;
        case (stateQ)
            GREEN_BASE, GREEN_EXT: begin
                green[phaseQ] = 1'b1;
                red[phaseQ]   = 1'b0;
            end
            YELLOW: begin
                yellow[phaseQ] = 1'b1;
                red[phaseQ]    = 1'b0;
            end
            WALK: walk[phaseQ] = 1'b1;
            default: ;
        endcase
    end

    assign phase     = phaseQ;
    assign state     = stateQ;
    assign walk_pend = walkPendQ;

endmodule
